// File: rtl/dds_wave_gen.sv
// DDS waveform generator: 32-bit phase accumulator feeding a 3-stage
// sample pipeline (accumulator, ROM address, waveform mux/output).
module dds_wave_gen #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        wave_select,
    input  logic [ACC_W-1:0]  freq_word,
    input  logic [ADDR_W-1:0] phase_word,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid
);

    logic [ACC_W-1:0]  acc;
    logic [3:0]        sel_q;
    logic [3:0]        sel_d1;
    logic [3:0]        sel_d2;
    logic              en_q;
    logic              en_d1;
    logic              en_d2;
    logic [ADDR_W-1:0] a_d;
    logic [DATA_W-1:0] wave;
    logic [DATA_W-1:0] tri_field;
    logic              restart;
    logic              unused_bits;

    assign restart = (wave_select != sel_q);

    // A select change forces phase 0 and takes priority over advancing
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc   <= '0;
            sel_q <= '0;
            en_q  <= 1'b0;
        end else begin
            if (restart) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + freq_word;
            end
            sel_q <= wave_select;
            en_q  <= en;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rom_addr <= '0;
            sel_d1   <= '0;
            en_d1    <= 1'b0;
        end else begin
            rom_addr <= acc[ACC_W-1 -: ADDR_W] + phase_word;
            sel_d1   <= sel_q;
            en_d1    <= en_q;
        end
    end

    // a_d lines up with rom_data, which the ROM returns one cycle late
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_d    <= '0;
            sel_d2 <= '0;
            en_d2  <= 1'b0;
        end else begin
            a_d    <= rom_addr;
            sel_d2 <= sel_d1;
            en_d2  <= en_d1;
        end
    end

    assign tri_field   = a_d[ADDR_W-2 -: DATA_W];
    assign unused_bits = ^a_d;

    always_comb begin
        wave = '0;
        case (sel_d2)
            4'b0001: wave = rom_data;
            4'b0010: wave = a_d[ADDR_W-1] ? '0 : '1;
            4'b0100: wave = a_d[ADDR_W-1] ? ~tri_field : tri_field;
            4'b1000: wave = a_d[ADDR_W-1 -: DATA_W];
            default: wave = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dac_data  <= '0;
            dac_valid <= 1'b0;
        end else begin
            dac_data  <= wave;
            dac_valid <= en_d2;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: vector table, directed
// waveform sequences and randomized stimulus against a phase model.
module tb_dds_wave_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  wave_select = '0;
    logic [31:0] freq_word = '0;
    logic [11:0] phase_word = '0;
    logic        en = 1'b0;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [7:0]  dac_data;
    logic        dac_valid;

    int checks = 0;
    int errors = 0;

    dds_wave_gen dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .wave_select(wave_select),
        .freq_word  (freq_word),
        .phase_word (phase_word),
        .en         (en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dac_data   (dac_data),
        .dac_valid  (dac_valid)
    );

    always #10 sys_clk = ~sys_clk;

    // Synchronous sine ROM stand-in: word = low address byte
    always @(posedge sys_clk) rom_data <= rom_addr[7:0];

    typedef struct {
        logic [31:0] acc;
        logic [3:0]  sel;
        logic        en;
    } st_t;

    typedef struct {
        logic [3:0]  ws;
        logic [11:0] pw;
        logic [7:0]  exp;
    } vec_t;

    st_t         hist[$];
    logic [11:0] pw_hist[$];
    logic [31:0] m_acc;
    logic [3:0]  m_sel;
    vec_t        vecs[$];
    logic [7:0]  tri_s[4096];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_wave(input logic [3:0] s,
                                            input logic [11:0] addr);
        int v;
        v = int'(addr);
        case (s)
            4'b0001: return 8'(v % 256);
            4'b0010: return (v < 2048) ? 8'd255 : 8'd0;
            4'b0100: return (v < 2048) ? 8'(v / 8)
                                       : 8'(255 - (v - 2048) / 8);
            4'b1000: return 8'(v / 16);
            default: return 8'd0;
        endcase
    endfunction

    task automatic model_reset();
        st_t z;
        z.acc = '0;
        z.sel = '0;
        z.en  = 1'b0;
        m_acc = '0;
        m_sel = '0;
        hist.delete();
        pw_hist.delete();
        for (int i = 0; i < 4; i++) begin
            hist.push_back(z);
            pw_hist.push_back('0);
        end
    endtask

    // One clock: advance the phase model at the edge, compare at negedge
    task automatic tick();
        st_t         s;
        logic [11:0] ea;
        logic [11:0] a;
        @(posedge sys_clk);
        if (wave_select != m_sel) m_acc = '0;
        else if (en) m_acc = m_acc + freq_word;
        m_sel = wave_select;
        s.acc = m_acc;
        s.sel = m_sel;
        s.en  = en;
        hist.push_back(s);
        pw_hist.push_back(phase_word);
        if (hist.size() > 8) hist.pop_front();
        if (pw_hist.size() > 8) pw_hist.pop_front();
        @(negedge sys_clk);
        ea = hist[hist.size()-2].acc[31:20] + pw_hist[pw_hist.size()-1];
        s  = hist[hist.size()-4];
        a  = s.acc[31:20] + pw_hist[pw_hist.size()-3];
        check("model_rom_addr", int'(rom_addr), int'(ea));
        check("model_dac_data", int'(dac_data), int'(ref_wave(s.sel, a)));
        check("model_dac_valid", int'(dac_valid), int'(s.en));
    endtask

    initial begin
        int wraps;
        int highs;
        int prev;
        int asym;
        int frz;
        int ra;
        logic [3:0] codes[5];

        vecs.push_back('{4'b0100, 12'd1024, 8'd128});
        vecs.push_back('{4'b0100, 12'd2047, 8'd255});
        vecs.push_back('{4'b0100, 12'd2048, 8'd255});
        vecs.push_back('{4'b0100, 12'd4095, 8'd0});
        vecs.push_back('{4'b1000, 12'd4095, 8'd255});
        vecs.push_back('{4'b1000, 12'd16,   8'd1});
        vecs.push_back('{4'b0010, 12'd2047, 8'd255});
        vecs.push_back('{4'b0010, 12'd2048, 8'd0});
        vecs.push_back('{4'b0001, 12'h3A5,  8'hA5});
        vecs.push_back('{4'b0000, 12'd100,  8'd0});
        vecs.push_back('{4'b0011, 12'd100,  8'd0});
        vecs.push_back('{4'b1111, 12'd5,    8'd0});
        vecs.push_back('{4'b1000, 12'd0,    8'd0});

        // Power-on reset
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset_dac_data", int'(dac_data), 0);
        check("reset_dac_valid", int'(dac_valid), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        sys_rst_n = 1'b1;
        model_reset();

        // Mux table: fw=0 pins acc at 0 so phase_word selects the address
        en = 1'b1;
        tick();
        foreach (vecs[i]) begin
            wave_select = vecs[i].ws;
            phase_word  = vecs[i].pw;
            repeat (4) tick();
            check("vec_dac_data", int'(dac_data), int'(vecs[i].exp));
        end

        // Sawtooth over one full period plus margin
        wave_select = 4'b0000;
        phase_word  = '0;
        repeat (3) tick();
        prev  = int'(dac_data);
        wraps = 0;
        wave_select = 4'b1000;
        freq_word   = 32'h0010_0000;
        repeat (4200) begin
            tick();
            if (prev == 255 && dac_data == 8'd0) wraps++;
            prev = int'(dac_data);
        end
        check("saw_wraps", wraps, 1);

        // Mid-period switch to square: first 8'hFF three edges later
        wave_select = 4'b0010;
        repeat (4) tick();
        check("switch_square_first", int'(dac_data), 255);
        highs = 0;
        repeat (4096) begin
            tick();
            if (dac_data == 8'hFF) highs++;
        end
        check("square_high_count", highs, 2048);
        phase_word = 12'd1024;
        repeat (1000) tick();

        // Triangle: one full period captured for shape checks
        phase_word  = '0;
        wave_select = 4'b0100;
        repeat (3) tick();
        for (int j = 0; j < 4096; j++) begin
            tick();
            tri_s[j] = dac_data;
        end
        check("tri_1024", int'(tri_s[1024]), 128);
        check("tri_2047", int'(tri_s[2047]), 255);
        check("tri_2048", int'(tri_s[2048]), 255);
        check("tri_4095", int'(tri_s[4095]), 0);
        asym = 0;
        for (int j = 0; j < 2048; j++)
            if (tri_s[j] != tri_s[4095-j]) asym++;
        check("tri_symmetry", asym, 0);

        // Enable low for 10 cycles
        repeat (300) tick();
        en = 1'b0;
        tick();
        tick();
        ra = int'(rom_addr);
        tick();
        check("en_valid_still_high", int'(dac_valid), 1);
        frz = int'(dac_data);
        tick();
        check("en_valid_low", int'(dac_valid), 0);
        repeat (6) begin
            tick();
            check("en_dac_frozen", int'(dac_data), frz);
        end
        check("en_addr_frozen", int'(rom_addr), ra);
        en = 1'b1;
        repeat (20) tick();

        // Asynchronous reset mid-run, released with no select
        #3 sys_rst_n = 1'b0;
        #1;
        check("midreset_dac_data", int'(dac_data), 0);
        check("midreset_dac_valid", int'(dac_valid), 0);
        check("midreset_rom_addr", int'(rom_addr), 0);
        wave_select = 4'b0000;
        en = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        repeat (20) tick();
        check("post_reset_dac_zero", int'(dac_data), 0);

        // Randomized operation
        codes[0] = 4'b0001;
        codes[1] = 4'b0010;
        codes[2] = 4'b0100;
        codes[3] = 4'b1000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                codes[4] = 4'($urandom);
                wave_select = codes[$urandom_range(0, 4)];
            end
            if ($urandom_range(0, 99) < 5)
                freq_word = $urandom_range(0, 1)
                          ? 32'($urandom_range(0, 15)) << 20
                          : 32'($urandom);
            if ($urandom_range(0, 99) < 5)
                phase_word = 12'($urandom);
            en = ($urandom_range(0, 99) < 80);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Direct digital synthesis (DDS) waveform generator that sits directly downstream of the key-driven waveform selector. It takes the one-hot `wave_select` code and a frequency tuning word, runs a 32-bit phase accumulator, and produces 8-bit DAC samples.
- Square, triangle and sawtooth samples are computed arithmetically from phase.
- Sine samples come from an external synchronous sine ROM that this block addresses.

## Interface
Parameters:
- `ACC_W`, 32, phase accumulator width.
- `ADDR_W`, 12, phase/ROM address width. Constraint: ADDR_W-1 >= DATA_W.
- `DATA_W`, 8, sample width.

Ports:
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `wave_select` in 4: one-hot waveform code.
  - 4'b0001 sine
  - 4'b0010 square
  - 4'b0100 triangle
  - 4'b1000 sawtooth
- `freq_word` in ACC_W: phase increment per clock. Output frequency = freq_word × 50 MHz / 2^ACC_W.
- `phase_word` in ADDR_W: phase offset, added modulo 2^ADDR_W.
- `en` in 1: accumulator advance enable.
- `rom_addr` out ADDR_W: sine ROM address, registered.
- `rom_data` in DATA_W: sine ROM output, valid 1 cycle after `rom_addr`.
- `dac_data` out DATA_W: output sample, registered.
- `dac_valid` out 1: `dac_data` was produced from an enabled accumulator step.

## Operation
- **Stage 0, accumulator:**
  - `en`=1: acc <= acc + freq_word, mod 2^ACC_W, natural wrap.
  - `en`=0: acc holds.
  - `freq_word` is sampled every cycle; a change takes effect on the next add.
- **Phase restart:** `sel_q` is the registered copy of `wave_select`.
  - When `wave_select` != `sel_q`, acc <= 0 that cycle, regardless of `en`.
  - `sel_q` updates the same cycle.
  - The new waveform therefore always starts at phase 0.
- **Stage 1, address:** rom_addr <= acc[ACC_W-1 -: ADDR_W] + phase_word, mod 2^ADDR_W.
  - `sel_q` is delayed alongside as `sel_d1`.
  - `en` is delayed alongside as `en_d1`.
- **Stage 2, waveform mux:** `a` = `rom_addr` register value, delayed one cycle to `a_d` so it aligns with `rom_data`.
  - sine: `rom_data`.
  - square: a_d[ADDR_W-1]==0 → all ones (8'hFF), else 0.
  - triangle: a_d[ADDR_W-1]==0 → a_d[ADDR_W-2 -: DATA_W], else the bitwise inverse of that field. Rises 0→255 over the first half, falls 255→0 over the second half.
  - sawtooth: a_d[ADDR_W-1 -: DATA_W].
  - any `sel_d2` not exactly one-hot, including 4'b0000: `dac_data` = 0.
- **Output:** `dac_data` registered from the stage-2 mux. `dac_valid` = `en` delayed to align with `dac_data`.
- **Reset values:** acc=0, sel_q/sel_d1/sel_d2=0, rom_addr=0, a_d=0, dac_data=0, dac_valid=0.
  - Reset mid-operation clears all stages immediately (asynchronous).
  - After reset `dac_data` stays 0 until a valid one-hot select arrives.

## Timing
- Latency from acc register update (edge n) to `dac_data`:
  - `rom_addr` at edge n+1
  - `rom_data`/`a_d` aligned at edge n+2
  - `dac_data` at edge n+3
- `wave_select` change at edge k (`sel_q` updates and acc=0 at k): first sample of the new waveform at phase 0 appears on `dac_data` at edge k+3.
- Simultaneous `wave_select` change and `en`=1: the restart wins; acc=0, not 0+freq_word.
- `freq_word`=0: output is constant at the current phase.
- Accumulator wrap at 2^ACC_W: seamless, no glitch, no extra cycle.
- `phase_word` change: applies at the next stage-1 register update.
- Throughput: one sample per clock while `en`=1.

## Test plan
- **Reset:** assert `sys_rst_n`=0 mid-run → `dac_data`=0, `dac_valid`=0, `rom_addr`=0 immediately. After release with `wave_select`=0 and `en`=1 → `dac_data` remains 0.
- **Sawtooth:** `wave_select`=4'b1000, `freq_word`=2^20, `en`=1 → `rom_addr` increments by 1 per cycle; `dac_data` steps +1 every 16 cycles, 0→255; period 4096 cycles; 255→0 at wrap.
- **Square, with phase offset:** `wave_select`=4'b0010, `freq_word`=2^20.
  - `phase_word`=0 → 2048 cycles of 8'hFF then 2048 cycles of 0.
  - `phase_word`=1024 → the high run starts 1024 cycles earlier relative to acc=0.
- **Triangle:** `wave_select`=4'b0100, `freq_word`=2^20.
  - `dac_data` = 128 at address 1024, 255 at 2047 and 2048, 0 at 4095.
  - Sequence is symmetric.
- **Sine path:** `wave_select`=4'b0001; bench ROM returns `rom_data` = addr[7:0] one cycle after `rom_addr` → `dac_data` equals the ROM word for the address issued 2 cycles earlier.
- **Select change and enable:**
  - Switch saw → square mid-period → acc=0 that cycle; first square sample (8'hFF) on `dac_data` 3 cycles later.
  - `en`=0 for 10 cycles → `dac_data` frozen, `dac_valid` low 3 cycles after `en` falls, accumulator value unchanged.
